// File: rtl/cirno9_sram_resp.sv
// cirno9_sram_resp
// Word-organised SRAM responder with a fixed, parameterised response latency.
// A request is a read (i_sram_ren), a byte-masked write (i_sram_wen != 0) or
// both at once. It is captured in IDLE and held through LAT wait cycles. The
// block then answers with a one-cycle o_hs_ram4ls_rdy pulse. o_rdat carries
// the word as it reads after any write of the same access.
//
// Parameters
//   AW  : word-address width, array depth is 2**AW 32-bit words
//   LAT : extra wait cycles before each response (0..15)
//
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   i_sram_ren       : read request, held by the initiator until rdy
//   i_sram_wen[3:0]  : byte-lane write enables
//   i_adr[31:0]      : byte address, only bits [AW+1:2] are used
//   i_wdat[31:0]     : write data
//   o_rdat[31:0]     : response data, held until the next response
//   o_hs_ram4ls_rdy  : one-cycle completion pulse
//   o_busy           : high while an accepted request is in flight

module cirno9_sram_resp #(
    parameter int AW  = 10,
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_sram_ren,
    input  logic [3:0]  i_sram_wen,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_rdat,
    output logic        o_hs_ram4ls_rdy,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_wordIdx;
    logic [31:0]     r_wdat;
    logic [3:0]      r_wen;
    logic            r_ren;
    logic [31:0]     r_rdat;
    logic [31:0]     r_mem [0:(2**AW)-1];

    logic            w_req;
    logic [AW-1:0]   w_inIdx;
    logic [AW-1:0]   w_mergeIdx;
    logic [3:0]      w_mergeWen;
    logic [31:0]     w_mergeWdat;
    logic [31:0]     w_arrWord;
    logic [31:0]     w_merged;
    logic            w_commit;

    assign w_req   = i_sram_ren | (|i_sram_wen);
    assign w_inIdx = i_adr[AW+1:2];

    // With LAT=0 the block enters DONE straight from IDLE. The request
    // registers are still being loaded on that edge, so the merge must take
    // the live inputs. In every other case it uses the latched copy.
    always_comb begin
        w_mergeIdx  = r_wordIdx;
        w_mergeWen  = r_wen;
        w_mergeWdat = r_wdat;
        if (r_state == IDLE) begin
            w_mergeIdx  = w_inIdx;
            w_mergeWen  = i_sram_wen;
            w_mergeWdat = i_wdat;
        end
    end

    assign w_arrWord = r_mem[w_mergeIdx];

    always_comb begin
        w_merged = w_arrWord;
        for (int k = 0; k < 4; k++) begin
            if (w_mergeWen[k]) begin
                w_merged[8*k +: 8] = w_mergeWdat[8*k +: 8];
            end
        end
    end

    // State register, wait counter, captured request and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_wordIdx <= '0;
            r_wdat    <= 32'h0;
            r_wen     <= 4'h0;
            r_ren     <= 1'b0;
            r_rdat    <= 32'h0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_req) begin
                r_wordIdx <= w_inIdx;
                r_wdat    <= i_wdat;
                r_wen     <= i_sram_wen;
                r_ren     <= i_sram_ren;
                r_cnt     <= 4'(LAT);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // DONE is only ever reached from IDLE or WAIT, so this fires
            // once, on the edge that enters DONE.
            if (w_nextState == DONE) begin
                r_rdat <= w_merged;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_nextState = (LAT == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so rdy and busy cannot
    // glitch on input activity.
    always_comb begin
        o_hs_ram4ls_rdy = (r_state == DONE);
        o_busy          = (r_state == WAIT) || (r_state == DONE);
    end

    assign o_rdat = r_rdat;

    // The array write lands on the edge leaving DONE. Reset forces the state
    // out of DONE asynchronously, and the explicit rst_n term keeps an
    // aborted access from committing. The array itself is never reset.
    assign w_commit = rst_n && (r_state == DONE) && (r_ren || (|r_wen));

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wen[k]) begin
                    r_mem[r_wordIdx][8*k +: 8] <= r_wdat[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cirno9_sram_resp.sv
// Testbench for cirno9_sram_resp.
// The main instance runs with AW=10 and LAT=2. A driver issues requests and
// pushes the expected response word and its expected rdy cycle into a queue.
// A separate monitor pops that queue on every rdy pulse. The expected word
// comes from a plain array model of the memory with byte-lane merging. A
// second instance with LAT=0 is used for the back-to-back read sequence.

module tb_cirno9_sram_resp;

    localparam int AW  = 10;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          sampleEdge;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        ren;
    logic [3:0]  wen;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        rdy;
    logic        busy;

    logic        ren0;
    logic [3:0]  wen0;
    logic [31:0] adr0;
    logic [31:0] wdat0;
    logic [31:0] rdat0;
    logic        rdy0;
    logic        busy0;

    int          checks;
    int          failures;
    int          edgeCount;
    exp_t        expQ[$];
    logic [31:0] refMem [0:(2**AW)-1];

    cirno9_sram_resp #(.AW(AW), .LAT(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_sram_ren      (ren),
        .i_sram_wen      (wen),
        .i_adr           (adr),
        .i_wdat          (wdat),
        .o_rdat          (rdat),
        .o_hs_ram4ls_rdy (rdy),
        .o_busy          (busy)
    );

    cirno9_sram_resp #(.AW(AW), .LAT(0)) dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_sram_ren      (ren0),
        .i_sram_wen      (wen0),
        .i_adr           (adr0),
        .i_wdat          (wdat0),
        .o_rdat          (rdat0),
        .o_hs_ram4ls_rdy (rdy0),
        .o_busy          (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, act, exp, edgeCount);
        end
    endtask

    // Issue one request to the LAT=2 instance and hold it until rdy.
    task automatic applyStimulus(input logic r, input logic [3:0] w,
                                 input logic [31:0] a, input logic [31:0] d);
        int          idx;
        logic [31:0] m;
        exp_t        e;
        bit          got;
        @(negedge clk);
        checkOutput("idleBusy", {31'h0, busy}, 32'h0);
        idx = int'(a[AW+1:2]);
        m   = refMem[idx];
        for (int k = 0; k < 4; k++) begin
            if (w[k]) m[8*k +: 8] = d[8*k +: 8];
        end
        if (w != 4'h0) refMem[idx] = m;
        e.data       = m;
        e.sampleEdge = edgeCount + 1;
        expQ.push_back(e);
        ren  = r;
        wen  = w;
        adr  = a;
        wdat = d;
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (rdy) begin
                got = 1'b1;
            end else begin
                checkOutput("waitBusy", {31'h0, busy}, 32'h1);
                adr  = $urandom;
                wdat = $urandom;
            end
        end
        ren = 1'b0;
        wen = 4'h0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: got no rdy expected rdy within 40 cycles");
            if (expQ.size() > 0) void'(expQ.pop_front());
        end
    endtask

    // Monitor: every rdy pulse of the main instance must match the oldest
    // outstanding expectation in both data and cycle.
    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spuriousRdy: got rdy=1 expected no response at edge %0d", edgeCount);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rdat", rdat, e.data);
                checkOutput("latency", edgeCount, e.sampleEdge + LAT);
                checkOutput("rdyBusy", {31'h0, busy}, 32'h1);
            end
        end
    end

    initial begin
        int          idx;
        int          op;
        logic [31:0] a;
        logic [3:0]  w;
        bit          got;

        checks    = 0;
        failures  = 0;
        edgeCount = 0;
        rst_n = 1'b0;
        ren = 1'b0; wen = 4'h0; adr = 32'h0; wdat = 32'h0;
        ren0 = 1'b0; wen0 = 4'h0; adr0 = 32'h0; wdat0 = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rstRdat", rdat, 32'h0);
        checkOutput("rstRdy", {31'h0, rdy}, 32'h0);
        checkOutput("rstBusy", {31'h0, busy}, 32'h0);
        checkOutput("rstRdat0", rdat0, 32'h0);
        checkOutput("rstBusy0", {31'h0, busy0}, 32'h0);
        rst_n = 1'b1;

        // Give words 0..31 known contents.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 4'hF, 32'(i) << 2, $urandom);
        end

        // Directed cases.
        applyStimulus(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b1, 4'h0, 32'h10, 32'h0);
        applyStimulus(1'b0, 4'b0010, 32'h10, 32'h0000AA00);
        applyStimulus(1'b1, 4'h0, 32'h10, 32'h0);
        applyStimulus(1'b0, 4'hF, 32'h1010, 32'h12345678);
        applyStimulus(1'b1, 4'h0, 32'h13, 32'h0);
        applyStimulus(1'b0, 4'hF, 32'h18, 32'h11223344);
        applyStimulus(1'b1, 4'b1000, 32'h18, 32'h7F000000);

        // Random mix of reads, writes and combined accesses with aliased
        // upper address bits and random byte offsets.
        for (int i = 0; i < 60; i++) begin
            op  = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, 31));
            a   = ($urandom & 32'hFFFFF003) | (32'(idx) << 2);
            w   = (op == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            applyStimulus(op != 1, w, a, $urandom);
        end

        // Reset in the middle of a write must abort it.
        applyStimulus(1'b0, 4'hF, 32'h14, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h18, 32'h0);
        @(negedge clk);
        wen  = 4'hF;
        adr  = 32'h14;
        wdat = 32'hFFFFFFFF;
        @(negedge clk);
        checkOutput("abortBusy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortRdat", rdat, 32'h0);
        checkOutput("abortRdy", {31'h0, rdy}, 32'h0);
        checkOutput("abortBusyLow", {31'h0, busy}, 32'h0);
        @(negedge clk);
        wen   = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("abortNoRdy", {31'h0, rdy}, 32'h0);
        end
        checkOutput("abortRdatHeld", rdat, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h14, 32'h0);

        // LAT=0 instance: seed one word, then hold a read continuously.
        @(negedge clk);
        wen0  = 4'hF;
        adr0  = 32'h40;
        wdat0 = 32'hCAFEF00D;
        got   = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rdy0) begin
                got = 1'b1;
                checkOutput("lat0WriteRdat", rdat0, 32'hCAFEF00D);
            end
        end
        wen0 = 4'h0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL lat0Timeout: got no rdy expected rdy within 10 cycles");
        end
        @(negedge clk);
        ren0 = 1'b1;
        adr0 = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checkOutput("lat0Rdy", {31'h0, rdy0}, 32'(c % 2));
            checkOutput("lat0Busy", {31'h0, busy0}, 32'(c % 2));
            if (c % 2 == 1) checkOutput("lat0Rdat", rdat0, 32'hCAFEF00D);
        end
        ren0 = 1'b0;

        repeat (4) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cirno9_sram_resp.md
CIRNO9_SRAM_RESP -- requirements
Module: cirno9_sram_resp

Interface
REQ-001 Parameter AW, default 10: word-address width; array depth is 2**AW 32-bit words.
REQ-002 Parameter LAT, default 1, legal range 0..15: number of extra wait cycles inserted before each response.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 Port i_sram_ren, input, 1 bit: read request, held high by the initiator until the response.
REQ-006 Port i_sram_wen, input, 4 bits: byte write enables; bit k selects byte lane k (bits 8k+7:8k).
REQ-007 Port i_adr, input, 32 bits: byte address of the access.
REQ-008 Port i_wdat, input, 32 bits: write data.
REQ-009 Port o_rdat, output, 32 bits: response data.
REQ-010 Port o_hs_ram4ls_rdy, output, 1 bit: one-cycle response pulse that completes the current request.
REQ-011 Port o_busy, output, 1 bit: high while a request is accepted and not yet completed.

Function
REQ-012 A request shall be present in a cycle when i_sram_ren is 1 or i_sram_wen is nonzero.
REQ-013 Word index = i_adr[AW+1:2]; i_adr[1:0] and i_adr[31:AW+2] shall be ignored, so out-of-range addresses wrap.
REQ-014 The state machine shall have three states: IDLE, WAIT, DONE.
REQ-015 In IDLE with a request present, the block shall latch the word index, i_wdat, i_sram_wen and i_sram_ren at the clock edge. It shall then go to WAIT with the counter set to LAT when LAT>0, or go directly to DONE when LAT=0.
REQ-016 In IDLE with no request present, the block shall stay in IDLE and latch nothing.
REQ-017 In WAIT, the counter shall decrement each cycle; the transition to DONE shall occur on the edge at which the counter equals 1.
REQ-018 DONE shall last exactly one cycle and shall always return to IDLE.
REQ-019 o_hs_ram4ls_rdy shall be a decode of the registered state (high only in DONE), so it is glitch-free.
REQ-020 Latency: a request sampled at edge N shall give o_hs_ram4ls_rdy high in cycle N+1+LAT; throughput is one access per LAT+2 cycles.
REQ-021 o_rdat shall be registered on the edge entering DONE with the merged word: for each lane k, latched wdat lane k if latched wen[k]=1, else the array lane k.
REQ-022 o_rdat shall hold its value until the next entry into DONE.
REQ-023 Enabled byte lanes shall be written to the array on the edge leaving DONE; disabled lanes shall be untouched.
REQ-024 Simultaneous ren=1 and nonzero wen shall be a legal request: the write is performed and o_rdat returns the post-write word.
REQ-025 ren=1 with wen=0 shall read only and never modify the array.
REQ-026 Input changes after the IDLE sample edge shall be ignored until the block is back in IDLE.
REQ-027 A request still held in the cycle after DONE shall be treated as a new request; the initiator drops or changes its request on seeing the rdy pulse.
REQ-028 o_busy shall be high in WAIT and DONE and low in IDLE.

Reset
REQ-029 When rst_n is low: state=IDLE, counter=0, o_hs_ram4ls_rdy=0, o_busy=0, o_rdat=32'h0, and all latched request registers cleared.
REQ-030 Reset asserted during WAIT or DONE shall abort the access: no array write occurs, and no rdy pulse occurs after release.
REQ-031 Array contents shall not be cleared by reset; after power-up they are undefined until written.
REQ-032 After rst_n rises, the first request shall be sampled at the first rising edge on which rst_n is high and a request is present.

Verification (AW=10, LAT=2 unless stated)
REQ-033 Write wen=4'hF, adr=32'h10, wdat=32'hDEADBEEF at edge 0 -> rdy high in cycle 3 only; then read adr=32'h10 -> o_rdat=32'hDEADBEEF with rdy.
REQ-034 Partial write wen=4'b0010, wdat=32'h0000AA00 to the same word -> following read returns 32'hDEADAAEF.
REQ-035 Aliasing: write 32'h12345678 to adr=32'h1010 (word index 4) -> read of adr=32'h13 returns 32'h12345678.
REQ-036 LAT=0, three back-to-back reads with the request held continuously -> rdy pulses in cycles 1, 3, 5; o_busy low in cycles 2 and 4.
REQ-037 rst_n pulsed low during WAIT of a write of 32'hFFFFFFFF over 32'h0 -> no rdy pulse, o_rdat=0; a later read returns 32'h0.
REQ-038 Combined ren=1, wen=4'b1000, wdat=32'h7F000000 on word 32'h11223344 -> o_rdat=32'h7F223344 in the rdy cycle.
